// File: rtl/axis2axi_wr.sv
// AXI-Stream to AXI4 write master: splits each transfer command into INCR bursts
// (<= MAX_BURST beats, never crossing a 4 KB page) with one burst outstanding at a time.
module axis2axi_wr #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned MAX_BURST  = 16,
    parameter int unsigned AXI_ID     = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    // Transfer command
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
    input  logic [19:0]             cmd_len_i,
    // Pixel stream
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata_i,
    input  logic                    s_axis_tvalid_i,
    input  logic                    s_axis_tlast_i,
    output logic                    s_axis_tready_o,
    // AXI4 write address channel
    output logic [3:0]              m_axi_awid_o,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr_o,
    output logic [7:0]              m_axi_awlen_o,
    output logic [2:0]              m_axi_awsize_o,
    output logic [1:0]              m_axi_awburst_o,
    output logic                    m_axi_awvalid_o,
    input  logic                    m_axi_awready_i,
    // AXI4 write data channel
    output logic [DATA_WIDTH-1:0]   m_axi_wdata_o,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb_o,
    output logic                    m_axi_wlast_o,
    output logic                    m_axi_wvalid_o,
    input  logic                    m_axi_wready_i,
    // AXI4 write response channel
    input  logic [1:0]              m_axi_bresp_i,
    input  logic                    m_axi_bvalid_i,
    output logic                    m_axi_bready_o,
    // Status
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_o
);

    localparam int unsigned StrbW  = DATA_WIDTH / 8;
    localparam int unsigned AxSize = $clog2(StrbW);

    typedef enum logic [2:0] {
        StIdle,
        StCalc,
        StAw,
        StW,
        StB,
        StDone
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [19:0]           rem_q, rem_d;
    logic [8:0]            beats_q, beats_d;
    logic [8:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [7:0]            awlen_q, awlen_d;
    logic                  err_q, err_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  cmd_rdy_q, cmd_rdy_d;

    logic [12:0]           room_bytes;
    logic [19:0]           room_beats;
    logic [19:0]           burst;
    logic                  last_beat;
    logic                  final_beat;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        beats_d    = beats_q;
        cnt_d      = cnt_q;
        awaddr_d   = awaddr_q;
        awlen_d    = awlen_q;
        err_d      = err_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        m_axi_awvalid_o = 1'b0;
        m_axi_wvalid_o  = 1'b0;
        m_axi_wlast_o   = 1'b0;
        m_axi_bready_o  = 1'b0;
        s_axis_tready_o = 1'b0;

        // Beats left before the 4 KB page ends; addr_q is always beat-aligned.
        room_bytes = 13'h1000 - {1'b0, addr_q[11:0]};
        room_beats = 20'(room_bytes >> AxSize);
        burst      = rem_q;
        if (burst > 20'(MAX_BURST)) begin
            burst = 20'(MAX_BURST);
        end
        if (burst > room_beats) begin
            burst = room_beats;
        end

        last_beat  = (cnt_q == beats_q - 9'd1);
        final_beat = last_beat && (rem_q == 20'(beats_q));

        unique case (state_q)
            StIdle: begin
                if (cmd_valid_i && cmd_rdy_q) begin
                    addr_d  = cmd_addr_i & ~ADDR_WIDTH'(StrbW - 1);
                    rem_d   = cmd_len_i;
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = (cmd_len_i == 20'd0) ? StDone : StCalc;
                end
            end
            StCalc: begin
                beats_d  = 9'(burst);
                awaddr_d = addr_q;
                awlen_d  = 8'(burst - 20'd1);
                cnt_d    = 9'd0;
                state_d  = StAw;
            end
            StAw: begin
                m_axi_awvalid_o = 1'b1;
                if (m_axi_awready_i) begin
                    state_d = StW;
                end
            end
            StW: begin
                m_axi_wvalid_o  = s_axis_tvalid_i;
                s_axis_tready_o = m_axi_wready_i;
                m_axi_wlast_o   = last_beat;
                if (s_axis_tvalid_i && m_axi_wready_i) begin
                    // tlast must coincide exactly with the command's final beat.
                    if (s_axis_tlast_i != final_beat) begin
                        err_d = 1'b1;
                    end
                    cnt_d = cnt_q + 9'd1;
                    if (last_beat) begin
                        state_d = StB;
                    end
                end
            end
            StB: begin
                m_axi_bready_o = 1'b1;
                if (m_axi_bvalid_i) begin
                    if (m_axi_bresp_i != 2'b00) begin
                        err_d = 1'b1;
                    end
                    addr_d  = addr_q + (ADDR_WIDTH'(beats_q) << AxSize);
                    rem_d   = rem_q - 20'(beats_q);
                    state_d = (rem_q == 20'(beats_q)) ? StDone : StCalc;
                end
            end
            StDone: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Registered so it reads 0 while in reset.
        cmd_rdy_d = (state_d == StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            rem_q     <= '0;
            beats_q   <= '0;
            cnt_q     <= '0;
            awaddr_q  <= '0;
            awlen_q   <= '0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cmd_rdy_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            beats_q   <= beats_d;
            cnt_q     <= cnt_d;
            awaddr_q  <= awaddr_d;
            awlen_q   <= awlen_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            cmd_rdy_q <= cmd_rdy_d;
        end
    end

    assign cmd_ready_o     = cmd_rdy_q;
    assign m_axi_awid_o    = 4'(AXI_ID);
    assign m_axi_awaddr_o  = awaddr_q;
    assign m_axi_awlen_o   = awlen_q;
    assign m_axi_awsize_o  = 3'(AxSize);
    assign m_axi_awburst_o = 2'b01;
    assign m_axi_wdata_o   = s_axis_tdata_i;
    assign m_axi_wstrb_o   = '1;
    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign err_o           = err_q;

endmodule

// File: tb/tb_axis2axi_wr.sv
// Directed bench for axis2axi_wr: command/stream driver, simple AXI slave and a
// handshake logger; expected bursts and data are hand-computed per test.
module tb_axis2axi_wr;

    localparam logic [63:0] DBase = 64'hA5A5_0000_0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid_i, cmd_ready_o;
    logic [31:0] cmd_addr_i;
    logic [19:0] cmd_len_i;
    logic [63:0] s_axis_tdata_i;
    logic        s_axis_tvalid_i, s_axis_tlast_i, s_axis_tready_o;
    logic [3:0]  m_axi_awid_o;
    logic [31:0] m_axi_awaddr_o;
    logic [7:0]  m_axi_awlen_o;
    logic [2:0]  m_axi_awsize_o;
    logic [1:0]  m_axi_awburst_o;
    logic        m_axi_awvalid_o, m_axi_awready_i;
    logic [63:0] m_axi_wdata_o;
    logic [7:0]  m_axi_wstrb_o;
    logic        m_axi_wlast_o, m_axi_wvalid_o, m_axi_wready_i;
    logic [1:0]  m_axi_bresp_i;
    logic        m_axi_bvalid_i, m_axi_bready_o;
    logic        busy_o, done_o, err_o;

    always #5 clk = ~clk;

    axis2axi_wr #(
        .DATA_WIDTH(64),
        .ADDR_WIDTH(32),
        .MAX_BURST (16),
        .AXI_ID    (0)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cmd_valid_i    (cmd_valid_i),
        .cmd_ready_o    (cmd_ready_o),
        .cmd_addr_i     (cmd_addr_i),
        .cmd_len_i      (cmd_len_i),
        .s_axis_tdata_i (s_axis_tdata_i),
        .s_axis_tvalid_i(s_axis_tvalid_i),
        .s_axis_tlast_i (s_axis_tlast_i),
        .s_axis_tready_o(s_axis_tready_o),
        .m_axi_awid_o   (m_axi_awid_o),
        .m_axi_awaddr_o (m_axi_awaddr_o),
        .m_axi_awlen_o  (m_axi_awlen_o),
        .m_axi_awsize_o (m_axi_awsize_o),
        .m_axi_awburst_o(m_axi_awburst_o),
        .m_axi_awvalid_o(m_axi_awvalid_o),
        .m_axi_awready_i(m_axi_awready_i),
        .m_axi_wdata_o  (m_axi_wdata_o),
        .m_axi_wstrb_o  (m_axi_wstrb_o),
        .m_axi_wlast_o  (m_axi_wlast_o),
        .m_axi_wvalid_o (m_axi_wvalid_o),
        .m_axi_wready_i (m_axi_wready_i),
        .m_axi_bresp_i  (m_axi_bresp_i),
        .m_axi_bvalid_i (m_axi_bvalid_i),
        .m_axi_bready_o (m_axi_bready_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .err_o          (err_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Logs are append-only (written by the logger); main records base indices.
    logic [31:0] aw_addr_log[$];
    logic [7:0]  aw_len_log[$];
    logic [63:0] w_data_log[$];
    logic        w_last_log[$];
    int          done_total = 0;
    int          b_total = 0;
    int          pending_b = 0;
    int          aw_base, w_base, done_base, b_base;
    bit          bp = 1'b0;
    int          err_burst = -1;
    logic [31:0] exp_addr[$];
    int          exp_len[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Handshake logger, sampled just before each rising edge.
    initial begin
        logic        aw_pend;
        logic [31:0] pa;
        logic [7:0]  pl;
        aw_pend = 1'b0;
        pa = '0;
        pl = '0;
        forever begin
            @(negedge clk);
            #4;
            if (!rst_n) begin
                aw_pend   = 1'b0;
                pending_b = 0;
            end else begin
                if (aw_pend) begin
                    chk("aw_addr_stable", 64'(m_axi_awaddr_o), 64'(pa));
                    chk("aw_len_stable", 64'(m_axi_awlen_o), 64'(pl));
                end
                aw_pend = m_axi_awvalid_o && !m_axi_awready_i;
                pa = m_axi_awaddr_o;
                pl = m_axi_awlen_o;
                if (m_axi_awvalid_o && m_axi_awready_i) begin
                    aw_addr_log.push_back(m_axi_awaddr_o);
                    aw_len_log.push_back(m_axi_awlen_o);
                end
                if (m_axi_wvalid_o && m_axi_wready_i) begin
                    w_data_log.push_back(m_axi_wdata_o);
                    w_last_log.push_back(m_axi_wlast_o);
                    if (m_axi_wlast_o) pending_b++;
                end
                if (m_axi_bvalid_i && m_axi_bready_o) begin
                    pending_b--;
                    b_total++;
                end
                if (done_o) done_total++;
            end
        end
    end

    // AXI slave: ready/response generation, optionally with random stalls.
    initial begin
        int bc_at_assert;
        bc_at_assert = 0;
        m_axi_awready_i = 1'b0;
        m_axi_wready_i  = 1'b0;
        m_axi_bvalid_i  = 1'b0;
        m_axi_bresp_i   = 2'b00;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_axi_awready_i = 1'b0;
                m_axi_wready_i  = 1'b0;
                m_axi_bvalid_i  = 1'b0;
            end else begin
                m_axi_awready_i = bp ? ($urandom_range(0, 2) == 0) : 1'b1;
                m_axi_wready_i  = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
                if (!(m_axi_bvalid_i && b_total == bc_at_assert)) begin
                    if (pending_b > 0 && (!bp || $urandom_range(0, 1) == 1)) begin
                        m_axi_bvalid_i = 1'b1;
                        m_axi_bresp_i  = (b_total - b_base == err_burst) ? 2'b10 : 2'b00;
                        bc_at_assert   = b_total;
                    end else begin
                        m_axi_bvalid_i = 1'b0;
                    end
                end
            end
        end
    end

    task automatic run_cmd(input logic [31:0] addr, input int len, input int tlast_beat,
                           input int gap_mod, input int abort_beat);
        int t;
        int i;
        int cyc;
        aw_base   = aw_addr_log.size();
        w_base    = w_data_log.size();
        done_base = done_total;
        b_base    = b_total;
        @(negedge clk);
        cmd_valid_i = 1'b1;
        cmd_addr_i  = addr;
        cmd_len_i   = 20'(len);
        t = 0;
        #4;
        while (!cmd_ready_o && t < 50) begin
            @(negedge clk);
            #4;
            t++;
        end
        if (t >= 50) chk("cmd_accept_timeout", 64'(0), 64'(1));
        @(negedge clk);
        cmd_valid_i = 1'b0;
        i = 0;
        cyc = 0;
        while (i < len && cyc < 3000 && !(abort_beat > 0 && i >= abort_beat)) begin
            s_axis_tvalid_i = (gap_mod == 0) || (cyc % gap_mod != 0);
            s_axis_tdata_i  = DBase + 64'(i);
            s_axis_tlast_i  = (i + 1 == tlast_beat);
            #4;
            if (s_axis_tvalid_i && s_axis_tready_o) i++;
            cyc++;
            @(negedge clk);
        end
        s_axis_tvalid_i = 1'b0;
        s_axis_tlast_i  = 1'b0;
        if (abort_beat == 0) begin
            if (i < len) chk("stream_timeout", 64'(i), 64'(len));
            t = 0;
            while (done_total == done_base && t < 3000) begin
                @(negedge clk);
                t++;
            end
            if (t >= 3000) chk("done_timeout", 64'(0), 64'(1));
        end
    endtask

    task automatic check_run(input string tag, input int len, input logic exp_err);
        int acc;
        int bi;
        int nw;
        chk({tag, "_aw_count"}, 64'(aw_addr_log.size() - aw_base), 64'(exp_addr.size()));
        for (int b = 0; b < exp_addr.size() && aw_base + b < aw_addr_log.size(); b++) begin
            chk({tag, "_awaddr"}, 64'(aw_addr_log[aw_base + b]), 64'(exp_addr[b]));
            chk({tag, "_awlen"}, 64'(aw_len_log[aw_base + b]), 64'(exp_len[b]));
        end
        nw = w_data_log.size() - w_base;
        chk({tag, "_w_count"}, 64'(nw), 64'(len));
        acc = 0;
        bi = 0;
        for (int i = 0; i < nw && i < len; i++) begin
            logic el;
            el = (bi < exp_len.size()) && (i == acc + exp_len[bi]);
            chk({tag, "_wdata"}, w_data_log[w_base + i], DBase + 64'(i));
            chk({tag, "_wlast"}, 64'(w_last_log[w_base + i]), 64'(el));
            if (el) begin
                acc += exp_len[bi] + 1;
                bi++;
            end
        end
        chk({tag, "_done_pulses"}, 64'(done_total - done_base), 64'(1));
        chk({tag, "_err"}, 64'(err_o), 64'(exp_err));
        chk({tag, "_busy"}, 64'(busy_o), 64'(0));
    endtask

    initial begin
        cmd_valid_i     = 1'b0;
        cmd_addr_i      = '0;
        cmd_len_i       = '0;
        s_axis_tdata_i  = '0;
        s_axis_tvalid_i = 1'b0;
        s_axis_tlast_i  = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        #1;
        chk("rst_cmd_ready", 64'(cmd_ready_o), 64'(0));
        chk("rst_awvalid", 64'(m_axi_awvalid_o), 64'(0));
        chk("rst_wvalid", 64'(m_axi_wvalid_o), 64'(0));
        chk("rst_wlast", 64'(m_axi_wlast_o), 64'(0));
        chk("rst_tready", 64'(s_axis_tready_o), 64'(0));
        chk("rst_bready", 64'(m_axi_bready_o), 64'(0));
        chk("rst_busy", 64'(busy_o), 64'(0));
        chk("rst_done", 64'(done_o), 64'(0));
        chk("rst_err", 64'(err_o), 64'(0));
        chk("rst_awaddr", 64'(m_axi_awaddr_o), 64'(0));
        chk("rst_awlen", 64'(m_axi_awlen_o), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #4;
        chk("idle_cmd_ready", 64'(cmd_ready_o), 64'(1));
        chk("awsize", 64'(m_axi_awsize_o), 64'(3));
        chk("awburst", 64'(m_axi_awburst_o), 64'(1));
        chk("awid", 64'(m_axi_awid_o), 64'(0));
        chk("wstrb", 64'(m_axi_wstrb_o), 64'hFF);

        // Basic single burst
        exp_addr = '{32'h1000};
        exp_len  = '{7};
        run_cmd(32'h1000, 8, 8, 0, 0);
        check_run("basic", 8, 1'b0);

        // Split into three bursts
        exp_addr = '{32'h2000, 32'h2080, 32'h2100};
        exp_len  = '{15, 15, 7};
        run_cmd(32'h2000, 40, 40, 0, 0);
        check_run("split", 40, 1'b0);

        // 4 KB boundary split
        exp_addr = '{32'h0FF0, 32'h1000};
        exp_len  = '{1, 1};
        run_cmd(32'h0FF0, 4, 4, 0, 0);
        check_run("page4k", 4, 1'b0);

        // Random slave stalls and stream gaps
        bp = 1'b1;
        exp_addr = '{32'h2000, 32'h2080, 32'h2100};
        exp_len  = '{15, 15, 7};
        run_cmd(32'h2000, 40, 40, 3, 0);
        check_run("backpressure", 40, 1'b0);
        bp = 1'b0;

        // SLVERR on the second of three bursts
        err_burst = 1;
        run_cmd(32'h2000, 40, 40, 0, 0);
        check_run("bresp_err", 40, 1'b1);
        err_burst = -1;

        // Early tlast on beat 5 of 8
        exp_addr = '{32'h1000};
        exp_len  = '{7};
        run_cmd(32'h1000, 8, 5, 0, 0);
        check_run("tlast_err", 8, 1'b1);

        // Zero-length command: done two cycles after accept, no AW, err cleared
        aw_base   = aw_addr_log.size();
        done_base = done_total;
        @(negedge clk);
        cmd_valid_i = 1'b1;
        cmd_addr_i  = 32'h5000;
        cmd_len_i   = 20'd0;
        #4;
        chk("len0_ready", 64'(cmd_ready_o), 64'(1));
        @(negedge clk);
        cmd_valid_i = 1'b0;
        #4;
        chk("len0_done_early", 64'(done_o), 64'(0));
        chk("len0_busy", 64'(busy_o), 64'(1));
        chk("len0_err_cleared", 64'(err_o), 64'(0));
        @(negedge clk);
        #4;
        chk("len0_done", 64'(done_o), 64'(1));
        chk("len0_busy_drop", 64'(busy_o), 64'(0));
        repeat (3) @(negedge clk);
        chk("len0_no_aw", 64'(aw_addr_log.size() - aw_base), 64'(0));
        chk("len0_one_done", 64'(done_total - done_base), 64'(1));

        // Reset after beat 3 of 8
        run_cmd(32'h3000, 8, 8, 0, 3);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_awvalid", 64'(m_axi_awvalid_o), 64'(0));
        chk("mid_rst_wvalid", 64'(m_axi_wvalid_o), 64'(0));
        chk("mid_rst_tready", 64'(s_axis_tready_o), 64'(0));
        chk("mid_rst_busy", 64'(busy_o), 64'(0));
        chk("mid_rst_cmd_ready", 64'(cmd_ready_o), 64'(0));
        chk("mid_rst_awaddr", 64'(m_axi_awaddr_o), 64'(0));
        chk("mid_rst_awlen", 64'(m_axi_awlen_o), 64'(0));
        chk("mid_rst_err", 64'(err_o), 64'(0));
        aw_base = aw_addr_log.size();
        w_base  = w_data_log.size();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_rst_no_aw", 64'(aw_addr_log.size() - aw_base), 64'(0));
        chk("post_rst_no_w", 64'(w_data_log.size() - w_base), 64'(0));
        exp_addr = '{32'h4000};
        exp_len  = '{3};
        run_cmd(32'h4000, 4, 4, 0, 0);
        check_run("after_rst", 4, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
